// File: rtl/inst_reg_queue_pkg.sv
// Shared constants and types for the instruction register prefetch queue.
package inst_reg_queue_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 4;

  // Queue update applied on a clock edge, from the enqueue/dequeue pair.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } q_op_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_reg_queue_mem.sv
// Prefetch queue storage: synchronous write, asynchronous read, no reset.
module ir_queue_mem
  import inst_reg_queue_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_reg_queue.sv
// Instruction register fed by a small prefetch queue, with empty-queue bypass and flush.
module inst_reg_queue
  import inst_reg_queue_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic [WIDTH-1:0]           DataIn,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       IRWre,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           InsOut,
  output logic                       InsValid,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  output logic                       Full
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data;
  logic             push, pop, bypass, enq, wr_en;
  q_op_t            op;

  assign Count   = count_q;
  assign Empty   = (count_q == '0);
  assign Full    = (count_q == CW'(DEPTH));
  assign InReady = !Full;

  // A word accepted while the queue is empty and IRWre is high goes straight
  // to InsOut, so it is never enqueued.
  always_comb begin
    push   = InValid && InReady;
    pop    = IRWre && !Empty;
    bypass = IRWre && Empty && push;
    enq    = push && !bypass;
    wr_en  = enq && !Flush;
    op     = OP_IDLE;
    if (enq && pop)  op = OP_BOTH;
    else if (enq)    op = OP_PUSH;
    else if (pop)    op = OP_POP;
  end

  ir_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (tail),
    .wr_data (DataIn),
    .rd_addr (head),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (Flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      case (op)
        OP_PUSH: count_q <= count_q + CW'(1);
        OP_POP:  count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      InsOut   <= '0;
      InsValid <= 1'b0;
    end else if (Flush) begin
      InsValid <= 1'b0;
    end else if (IRWre) begin
      if (pop) begin
        InsOut   <= rd_data;
        InsValid <= 1'b1;
      end else if (bypass) begin
        InsOut   <= DataIn;
        InsValid <= 1'b1;
      end else begin
        InsValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_reg_queue.sv
// Directed self-checking bench for inst_reg_queue (WIDTH=32, DEPTH=4).
module tb_inst_reg_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RSTn;
  logic [WIDTH-1:0] DataIn;
  logic             InValid;
  logic             InReady;
  logic             IRWre;
  logic             Flush;
  logic [WIDTH-1:0] InsOut;
  logic             InsValid;
  logic [CW-1:0]    Count;
  logic             Empty;
  logic             Full;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  inst_reg_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .DataIn   (DataIn),
    .InValid  (InValid),
    .InReady  (InReady),
    .IRWre    (IRWre),
    .Flush    (Flush),
    .InsOut   (InsOut),
    .InsValid (InsValid),
    .Count    (Count),
    .Empty    (Empty),
    .Full     (Full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_insout"}, 64'(InsOut), 64'h0);
    check({tag, "_insvalid"}, 64'(InsValid), 64'h0);
    check({tag, "_count"}, 64'(Count), 64'h0);
    check({tag, "_empty"}, 64'(Empty), 64'h1);
    check({tag, "_full"}, 64'(Full), 64'h0);
    check({tag, "_inready"}, 64'(InReady), 64'h1);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    InValid = 1'b1;
    DataIn  = w;
    cycle();
    InValid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn = 1'b0; DataIn = '0; InValid = 1'b0; IRWre = 1'b0; Flush = 1'b0;
    #3;
    check_reset_state("reset");
    cycle(); cycle();
    RSTn = 1'b1;

    // Two pushes, two pops, in order
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    check("fifo_count2", 64'(Count), 64'd2);
    check("fifo_insvalid_idle", 64'(InsValid), 64'h0);
    IRWre = 1'b1;
    cycle();
    check("fifo_pop1", 64'(InsOut), 64'h1111_1111);
    check("fifo_pop1_valid", 64'(InsValid), 64'h1);
    check("fifo_pop1_count", 64'(Count), 64'd1);
    cycle();
    check("fifo_pop2", 64'(InsOut), 64'h2222_2222);
    check("fifo_pop2_empty", 64'(Empty), 64'h1);

    // Advance on empty queue with no push: hold word, invalidate
    cycle();
    check("empty_adv_hold", 64'(InsOut), 64'h2222_2222);
    check("empty_adv_invalid", 64'(InsValid), 64'h0);

    // Bypass on empty queue
    InValid = 1'b1; DataIn = 32'hABCD_0001;
    cycle();
    InValid = 1'b0; IRWre = 1'b0;
    check("bypass_insout", 64'(InsOut), 64'hABCD_0001);
    check("bypass_valid", 64'(InsValid), 64'h1);
    check("bypass_count", 64'(Count), 64'd0);

    // Fill to DEPTH; 5th word must wait for a pop
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    check("full_flag", 64'(Full), 64'h1);
    check("full_inready", 64'(InReady), 64'h0);
    check("full_count", 64'(Count), 64'd4);
    InValid = 1'b1; DataIn = 32'hA000_0004;
    cycle(); cycle();
    check("full_ignored_count", 64'(Count), 64'd4);
    check("idle_hold_insout", 64'(InsOut), 64'hABCD_0001);
    check("idle_hold_valid", 64'(InsValid), 64'h1);
    IRWre = 1'b1;
    cycle();
    check("full_pop_insout", 64'(InsOut), 64'hA000_0000);
    check("full_pop_count", 64'(Count), 64'd3);
    check("full_pop_inready", 64'(InReady), 64'h1);
    IRWre = 1'b0;
    cycle();
    InValid = 1'b0;
    check("fifth_accepted", 64'(Count), 64'd4);
    IRWre = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cycle();
      check("full_drain", 64'(InsOut), 64'hA000_0000 + 64'(i));
    end
    IRWre = 1'b0;
    check("full_drain_empty", 64'(Empty), 64'h1);

    // Flush beats simultaneous push and pop
    for (int i = 0; i < 3; i++) push_word(32'hB000_0000 + 32'(i));
    check("preflush_count", 64'(Count), 64'd3);
    Flush = 1'b1; InValid = 1'b1; DataIn = 32'hB000_0003; IRWre = 1'b1;
    cycle();
    Flush = 1'b0; InValid = 1'b0;
    check("flush_count", 64'(Count), 64'd0);
    check("flush_insvalid", 64'(InsValid), 64'h0);
    check("flush_insout", 64'(InsOut), 64'hA000_0004);
    cycle();
    check("flush_discard_valid", 64'(InsValid), 64'h0);
    check("flush_discard_insout", 64'(InsOut), 64'hA000_0004);
    IRWre = 1'b0;
    push_word(32'hC000_0000);
    IRWre = 1'b1;
    cycle();
    IRWre = 1'b0;
    check("postflush_pop", 64'(InsOut), 64'hC000_0000);

    // Continuous push/pop at Count=2 across pointer wrap
    push_word(32'hD000_0000);
    push_word(32'hD000_0001);
    IRWre = 1'b1; InValid = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      DataIn = 32'hE000_0000 + 32'(k);
      cycle();
      check("stream_out", 64'(InsOut),
            (k < 2) ? (64'hD000_0000 + 64'(k)) : (64'hE000_0000 + 64'(k - 2)));
      check("stream_count", 64'(Count), 64'd2);
    end
    IRWre = 1'b0; InValid = 1'b0;

    // Asynchronous reset mid-burst with two words queued
    #2;
    RSTn = 1'b0;
    #1;
    check_reset_state("async_rst");
    #2;
    RSTn = 1'b1;
    cycle();
    push_word(32'hF000_0000);
    IRWre = 1'b1;
    cycle();
    IRWre = 1'b0;
    check("post_rst_pop", 64'(InsOut), 64'hF000_0000);
    check("post_rst_empty", 64'(Empty), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
